// File: rtl/rsa_cmd_controller.sv
// Command sequencer between the ARM command/data interface and one RSA exponentiation core.
// Loads five operands, starts the core, captures its result and returns it on a WRITE command.
module rsa_cmd_controller #(
  parameter int unsigned DATA_W         = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [31:0]       arm_to_fpga_cmd,
  input  logic              arm_to_fpga_cmd_valid,
  output logic              fpga_to_arm_done,
  input  logic              fpga_to_arm_done_read,
  input  logic              arm_to_fpga_data_valid,
  output logic              arm_to_fpga_data_ready,
  input  logic [DATA_W-1:0] arm_to_fpga_data,
  output logic              fpga_to_arm_data_valid,
  input  logic              fpga_to_arm_data_ready,
  output logic [DATA_W-1:0] fpga_to_arm_data,
  output logic              core_start,
  output logic              core_decrypt,
  output logic [DATA_W-1:0] core_msg,
  output logic [DATA_W-1:0] core_exp,
  output logic [DATA_W-1:0] core_n,
  output logic [DATA_W-1:0] core_rmodn,
  output logic [DATA_W-1:0] core_r2modn,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result,
  output logic [3:0]        leds
);

  typedef enum logic [2:0] {StIdle, StRx, StStart, StWait, StTx, StDone} state_e;

  localparam logic [4:0]  FullMask    = 5'b11111;
  localparam logic [31:0] TimeoutLast = TIMEOUT_CYCLES - 1;

  state_e            state_q, state_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [4:0]        mask_q, mask_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] op_q [5];
  logic [DATA_W-1:0] op_d [5];
  logic              start_q, start_d;
  logic              decrypt_q, decrypt_d;
  logic              err_q, err_d;
  logic              to_q, to_d;

  logic unused_cmd;
  assign unused_cmd = ^arm_to_fpga_cmd[31:2];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    op_d      = op_q;
    start_d   = 1'b0;
    decrypt_d = decrypt_q;
    err_d     = err_q;
    to_d      = to_q;

    unique case (state_q)
      StIdle: begin
        if (arm_to_fpga_cmd_valid) begin
          err_d = 1'b0;
          to_d  = 1'b0;
          unique case (arm_to_fpga_cmd[1:0])
            2'd0:    state_d = StRx;
            2'd2:    state_d = StTx;
            default: begin
              state_d = StStart;
              // Start pulse is registered so it lands exactly in the START cycle.
              if (mask_q == FullMask) begin
                start_d   = 1'b1;
                decrypt_d = arm_to_fpga_cmd[1];
              end
            end
          endcase
        end
      end
      StRx: begin
        if (arm_to_fpga_data_valid) begin
          for (int unsigned i = 0; i < 5; i++) begin
            if (ptr_q == 3'(i)) begin
              op_d[i]   = arm_to_fpga_data;
              mask_d[i] = 1'b1;
            end
          end
          ptr_d   = (ptr_q == 3'd4) ? 3'd0 : ptr_q + 3'd1;
          state_d = StDone;
        end
      end
      StStart: begin
        if (mask_q != FullMask) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          mask_d  = '0;
          ptr_d   = '0;
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        // core_done takes priority over a timeout in the same cycle.
        if (core_done) begin
          result_d = core_result;
          state_d  = StDone;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == TimeoutLast) begin
          to_d    = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StTx: begin
        if (fpga_to_arm_data_ready) state_d = StDone;
      end
      StDone: begin
        if (fpga_to_arm_done_read) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      mask_q    <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      start_q   <= 1'b0;
      decrypt_q <= 1'b0;
      err_q     <= 1'b0;
      to_q      <= 1'b0;
      for (int i = 0; i < 5; i++) op_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      start_q   <= start_d;
      decrypt_q <= decrypt_d;
      err_q     <= err_d;
      to_q      <= to_d;
      op_q      <= op_d;
    end
  end

  assign fpga_to_arm_done       = (state_q == StDone);
  assign arm_to_fpga_data_ready = (state_q == StRx);
  assign fpga_to_arm_data_valid = (state_q == StTx);
  assign fpga_to_arm_data       = result_q;
  assign core_start             = start_q;
  assign core_decrypt           = decrypt_q;
  assign core_msg               = op_q[0];
  assign core_exp               = op_q[1];
  assign core_n                 = op_q[2];
  assign core_rmodn             = op_q[3];
  assign core_r2modn            = op_q[4];
  assign leds                   = {to_q, err_q, state_q == StWait, state_q != StIdle};

endmodule
